// File: rtl/logic_gate_unit_if.sv
// Stream interface for logic_gate_unit.
// Upstream side:   A, B, MODE, IN_VALID -> unit; IN_READY <- unit.
// Downstream side: Y, Z, OUT_VALID <- unit; OUT_READY -> unit.
// slave modport is the unit, master modport is whoever drives/consumes it.
interface logic_gate_unit_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       MODE;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] Y;
    logic             Z;
    logic             OUT_VALID;
    logic             OUT_READY;

    modport slave (
        input  A, B, MODE, IN_VALID, OUT_READY,
        output IN_READY, Y, Z, OUT_VALID
    );

    modport master (
        output A, B, MODE, IN_VALID, OUT_READY,
        input  IN_READY, Y, Z, OUT_VALID
    );
endinterface

// File: rtl/logic_gate_unit.sv
// Registered bitwise logic unit with a 2-entry result buffer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : stream interface (slave side), operands in, result out
//   COUNT      : number of results delivered since reset (wraps)
// Entry 0 (head) lives directly in the Y/Z output registers so the outputs
// are flops and naturally hold their last value when the buffer empties.
module logic_gate_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    logic_gate_unit_if.slave   bus,
    output logic [CNT_W-1:0]   COUNT
);

    typedef enum logic [1:0] {
        OCC_0 = 2'd0,
        OCC_1 = 2'd1,
        OCC_2 = 2'd2
    } occ_e;

    occ_e             state_q, state_d;
    logic [WIDTH-1:0] head_y_q, head_y_d;
    logic             head_z_q, head_z_d;
    logic [WIDTH-1:0] tail_y_q, tail_y_d;
    logic             tail_z_q, tail_z_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [WIDTH-1:0] result;
    logic             result_zero;
    logic             push;
    logic             pop;

    // Bitwise function select
    always_comb begin
        result = '0;
        unique case (bus.MODE)
            3'b000: result = bus.A & bus.B;
            3'b001: result = bus.A | bus.B;
            3'b010: result = ~(bus.A & bus.B);
            3'b011: result = ~(bus.A | bus.B);
            3'b100: result = bus.A ^ bus.B;
            3'b101: result = ~(bus.A ^ bus.B);
            3'b110: result = ~bus.A;
            3'b111: result = bus.A;
        endcase
    end

    assign result_zero = (result == '0);

    // Handshakes use only registered ready/valid, so no OUT_READY -> IN_READY path
    assign push = bus.IN_VALID & in_ready_q;
    assign pop  = out_valid_q & bus.OUT_READY;

    // Occupancy FSM and buffer next-state
    always_comb begin
        state_d  = state_q;
        head_y_d = head_y_q;
        head_z_d = head_z_q;
        tail_y_d = tail_y_q;
        tail_z_d = tail_z_q;
        count_d  = pop ? count_q + CNT_W'(1) : count_q;

        unique case (state_q)
            OCC_0: begin
                if (push) begin
                    head_y_d = result;
                    head_z_d = result_zero;
                    state_d  = OCC_1;
                end
            end
            OCC_1: begin
                unique case ({push, pop})
                    2'b10: begin
                        tail_y_d = result;
                        tail_z_d = result_zero;
                        state_d  = OCC_2;
                    end
                    2'b01: begin
                        state_d = OCC_0;
                    end
                    // Head leaves as the new entry arrives: new entry is the head
                    2'b11: begin
                        head_y_d = result;
                        head_z_d = result_zero;
                    end
                    default: begin
                        state_d = OCC_1;
                    end
                endcase
            end
            OCC_2: begin
                if (pop) begin
                    head_y_d = tail_y_q;
                    head_z_d = tail_z_q;
                    state_d  = OCC_1;
                end
            end
            default: begin
                state_d = OCC_0;
            end
        endcase

        in_ready_d  = (state_d != OCC_2);
        out_valid_d = (state_d != OCC_0);
    end

    // State and storage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= OCC_0;
            head_y_q    <= '0;
            head_z_q    <= 1'b0;
            tail_y_q    <= '0;
            tail_z_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            head_y_q    <= head_y_d;
            head_z_q    <= head_z_d;
            tail_y_q    <= tail_y_d;
            tail_z_q    <= tail_z_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            count_q     <= count_d;
        end
    end

    assign bus.IN_READY  = in_ready_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.Y         = head_y_q;
    assign bus.Z         = head_z_q;
    assign COUNT         = count_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Self-checking bench for logic_gate_unit: vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_logic_gate_unit;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CNT_W2 = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic_gate_unit_if #(.WIDTH(WIDTH)) bus ();
    logic_gate_unit_if #(.WIDTH(WIDTH)) bus2 ();
    logic [CNT_W-1:0]  count;
    logic [CNT_W2-1:0] count2;

    logic_gate_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .COUNT (count)
    );

    logic_gate_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W2)) dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2),
        .COUNT (count2)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: result queue plus held output value
    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             z;
    } ent_t;

    ent_t             mq[$];
    logic [CNT_W-1:0] m_count;
    logic [WIDTH-1:0] last_y;
    logic             last_z;

    // Each mode is a 2-input truth table indexed by {a_bit, b_bit}
    function automatic logic [WIDTH-1:0] ref_op(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [2:0] mode);
        logic [3:0]       tt;
        logic [WIDTH-1:0] r;
        case (mode)
            3'd0:    tt = 4'b1000;
            3'd1:    tt = 4'b1110;
            3'd2:    tt = 4'b0111;
            3'd3:    tt = 4'b0001;
            3'd4:    tt = 4'b0110;
            3'd5:    tt = 4'b1001;
            3'd6:    tt = 4'b0011;
            default: tt = 4'b1100;
        endcase
        for (int i = 0; i < int'(WIDTH); i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_count = '0;
        last_y  = '0;
        last_z  = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        logic [WIDTH-1:0] ey;
        logic             ez;
        ey = (mq.size() > 0) ? mq[0].y : last_y;
        ez = (mq.size() > 0) ? mq[0].z : last_z;
        check({tag, ".in_ready"},  32'(bus.IN_READY),  32'(mq.size() < 2));
        check({tag, ".out_valid"}, 32'(bus.OUT_VALID), 32'(mq.size() > 0));
        check({tag, ".y"},         32'(bus.Y),         32'(ey));
        check({tag, ".z"},         32'(bus.Z),         32'(ez));
        check({tag, ".count"},     32'(count),         32'(m_count));
    endtask

    // One clock of stimulus on the main DUT, model update, then output check
    task automatic cycle(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] mode, input logic iv, input logic ordy);
        logic             acc;
        logic             pp;
        logic [WIDTH-1:0] r;
        bus.A = a; bus.B = b; bus.MODE = mode; bus.IN_VALID = iv; bus.OUT_READY = ordy;
        @(posedge clk);
        acc = iv && (mq.size() < 2);
        pp  = ordy && (mq.size() > 0);
        if (pp) begin
            void'(mq.pop_front());
            m_count = m_count + CNT_W'(1);
        end
        if (acc) begin
            r = ref_op(a, b, mode);
            mq.push_back('{y: r, z: (r == '0)});
        end
        if (mq.size() > 0) begin
            last_y = mq[0].y;
            last_z = mq[0].z;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        #1;
        check_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       mode;
        logic [WIDTH-1:0] y;
        logic             z;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{8'hF0, 8'h3C, 3'd0, 8'h30, 1'b0};
        tbl[1] = '{8'hF0, 8'h3C, 3'd1, 8'hFC, 1'b0};
        tbl[2] = '{8'hF0, 8'h3C, 3'd2, 8'hCF, 1'b0};
        tbl[3] = '{8'hF0, 8'h3C, 3'd3, 8'h03, 1'b0};
        tbl[4] = '{8'hF0, 8'h3C, 3'd4, 8'hCC, 1'b0};
        tbl[5] = '{8'hF0, 8'h3C, 3'd5, 8'h33, 1'b0};
        tbl[6] = '{8'hF0, 8'h3C, 3'd6, 8'h0F, 1'b0};
        tbl[7] = '{8'hF0, 8'h3C, 3'd7, 8'hF0, 1'b0};
        tbl[8] = '{8'hFF, 8'h00, 3'd3, 8'h00, 1'b1};
        tbl[9] = '{8'h00, 8'h00, 3'd3, 8'hFF, 1'b0};

        bus.A = '0; bus.B = '0; bus.MODE = '0; bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b0;
        bus2.A = '0; bus2.B = '0; bus2.MODE = '0; bus2.IN_VALID = 1'b0; bus2.OUT_READY = 1'b0;
        model_clear();
        rst_n = 1'b0;
        #12;
        check_outputs("reset");
        check("reset.count2", 32'(count2), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle("idle", 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);

        // Function sweep and zero flag, one result per cycle
        for (int i = 0; i < 10; i++) begin
            cycle("sweep", tbl[i].a, tbl[i].b, tbl[i].mode, 1'b1, 1'b1);
            check("tbl.y", 32'(bus.Y), 32'(tbl[i].y));
            check("tbl.z", 32'(bus.Z), 32'(tbl[i].z));
            if (i == 8) check("sweep.count8", 32'(count), 32'd8);
        end
        cycle("drain", 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        check("drain.count", 32'(count), 32'd10);
        check("drain.hold_y", 32'(bus.Y), 32'hFF);

        // Backpressure: two accepted, third held until space frees
        do_reset();
        cycle("bp", 8'h01, 8'h00, 3'd3, 1'b1, 1'b0);
        cycle("bp", 8'h02, 8'h00, 3'd3, 1'b1, 1'b0);
        check("bp.full_ready", 32'(bus.IN_READY), 32'd0);
        cycle("bp", 8'h04, 8'h00, 3'd3, 1'b1, 1'b0);
        check("bp.stall_y", 32'(bus.Y), 32'hFE);
        cycle("bp", 8'h04, 8'h00, 3'd3, 1'b1, 1'b1);
        check("bp.y2", 32'(bus.Y), 32'hFD);
        cycle("bp", 8'h04, 8'h00, 3'd3, 1'b1, 1'b1);
        check("bp.y3", 32'(bus.Y), 32'hFB);
        cycle("bp", 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        check("bp.count", 32'(count), 32'd3);
        check("bp.empty", 32'(bus.OUT_VALID), 32'd0);

        // Simultaneous push and pop at occupancy 1
        do_reset();
        cycle("pp", 8'h11, 8'h00, 3'd7, 1'b1, 1'b0);
        check("pp.head", 32'(bus.Y), 32'h11);
        cycle("pp", 8'h5A, 8'h00, 3'd7, 1'b1, 1'b1);
        check("pp.y", 32'(bus.Y), 32'h5A);
        check("pp.valid", 32'(bus.OUT_VALID), 32'd1);
        check("pp.ready", 32'(bus.IN_READY), 32'd1);
        check("pp.count", 32'(count), 32'd1);

        // Asynchronous reset with two entries buffered and COUNT = 5
        do_reset();
        for (int i = 0; i < 5; i++) cycle("pre", 8'(i + 1), 8'h00, 3'd7, 1'b1, 1'b1);
        cycle("pre", 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        cycle("pre", 8'hAA, 8'h00, 3'd7, 1'b1, 1'b0);
        cycle("pre", 8'hBB, 8'h00, 3'd7, 1'b1, 1'b0);
        check("pre.count", 32'(count), 32'd5);
        check("pre.full", 32'(bus.IN_READY), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check("arst.valid", 32'(bus.OUT_VALID), 32'd0);
        check("arst.ready", 32'(bus.IN_READY), 32'd1);
        check("arst.count", 32'(count), 32'd0);
        check("arst.y", 32'(bus.Y), 32'h00);
        check("arst.z", 32'(bus.Z), 32'd0);
        bus.IN_VALID = 1'b0;
        bus.OUT_READY = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle("post", 8'h3C, 8'h00, 3'd7, 1'b1, 1'b0);
        check("post.first_accept", 32'(bus.Y), 32'h3C);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle("rnd", 8'($urandom), 8'($urandom), 3'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
        end

        // Counter wrap on the narrow-counter instance: 5 deliveries -> 1
        @(posedge clk);
        #1;
        bus2.A = 8'h55; bus2.MODE = 3'd7; bus2.IN_VALID = 1'b1; bus2.OUT_READY = 1'b1;
        for (int i = 0; i < 5; i++) @(posedge clk);
        #1;
        bus2.IN_VALID = 1'b0;
        @(posedge clk);
        #1;
        check("wrap.count", 32'(count2), 32'd1);
        check("wrap.empty", 32'(bus2.OUT_VALID), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
